// File: rtl/expr_pipe_pkg.sv
// expr_pipe_pkg: shared mode encoding, default seed constant and reference expression
package expr_pipe_pkg;
   typedef enum logic {MODE_EXPR = 1'b0, MODE_ACC = 1'b1} mode_e;
   localparam logic [23:0] K_DEFAULT = 24'h478C28;
   // Reference for the default widths (IN_W=7, ACC_W=24); low OUT_W bits are the output.
   // In ACC mode the result is acc_next.
   function automatic logic [23:0] expr_ref(input logic [6:0] x, input mode_e mode, input logic [23:0] acc);
      logic [23:0] a, t0, t3;
      a = (K_DEFAULT - {17'd0, ~x}) | {17'd0, x};
      t0 = a - {17'd0, x};
      t3 = {17'd0, t0[23 -: 7]} + {17'd0, x};
      return (mode == MODE_ACC) ? acc + t0 : t0 - t3;
   endfunction
endpackage

// File: rtl/expr_pipe_stage.sv
// expr_pipe_stage: data+valid pipeline register with shift enable
// ports: clk, rst (sync, active-high), en (shift), d_valid/d (from upstream), q_valid/q (registered)
module expr_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         d_valid,
   input  logic [W-1:0] d,
   output logic         q_valid,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst) begin
         q_valid <= 1'b0;
         q <= '0;
      end else if (en) begin
         q_valid <= d_valid;
         q <= d;
      end
   end
endmodule

// File: rtl/expr_pipe_core.sv
// expr_pipe_core: three-stage valid/ready expression pipeline with optional running accumulator
// ports: clk, rst; in_valid/in_ready/input_data/in_mode (token in); acc_clear;
//        out_valid/out_ready/output_data (result out); out_count (accepted outputs, wraps)
import expr_pipe_pkg::*;
module expr_pipe_core #(
   parameter int IN_W = 7,
   parameter int OUT_W = 9,
   parameter int ACC_W = 24,
   parameter logic [ACC_W-1:0] K = ACC_W'(K_DEFAULT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  input_data,
   input  logic             in_mode,
   input  logic             acc_clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] output_data,
   output logic [15:0]      out_count
);
   localparam int S1_W = 1 + IN_W + ACC_W;
   localparam int S2_W = 1 + ACC_W + OUT_W;
   logic             advance, v1, v2;
   logic [IN_W-1:0]  nxi, x1;
   logic [ACC_W-1:0] a, a1, t0, t0_2, acc, acc_next;
   logic [OUT_W-1:0] t3, t3_2, res;
   logic [S1_W-1:0]  q1;
   logic [S2_W-1:0]  q2;
   logic             m1, m2;
   assign advance = !out_valid || out_ready;
   assign in_ready = advance;
   assign nxi = ~input_data;
   assign a = (K - ACC_W'(nxi)) | ACC_W'(input_data);
   expr_pipe_stage #(.W(S1_W)) u_s1 (
      .clk(clk), .rst(rst), .en(advance), .d_valid(in_valid),
      .d({in_mode, input_data, a}), .q_valid(v1), .q(q1)
   );
   assign m1 = q1[S1_W-1];
   assign x1 = q1[ACC_W +: IN_W];
   assign a1 = q1[ACC_W-1:0];
   assign t0 = a1 - ACC_W'(x1);
   // only the low OUT_W bits of t3 ever reach the output, so S2 keeps just those
   assign t3 = OUT_W'(t0[ACC_W-1 -: IN_W]) + OUT_W'(x1);
   expr_pipe_stage #(.W(S2_W)) u_s2 (
      .clk(clk), .rst(rst), .en(advance), .d_valid(v1),
      .d({m1, t0, t3}), .q_valid(v2), .q(q2)
   );
   assign m2 = q2[S2_W-1];
   assign t0_2 = q2[OUT_W +: ACC_W];
   assign t3_2 = q2[OUT_W-1:0];
   // clear-then-add when acc_clear coincides with an ACC token loading S3
   assign acc_next = (acc_clear ? '0 : acc) + t0_2;
   assign res = (m2 == MODE_ACC) ? acc_next[OUT_W-1:0] : t0_2[OUT_W-1:0] - t3_2;
   expr_pipe_stage #(.W(OUT_W)) u_s3 (
      .clk(clk), .rst(rst), .en(advance), .d_valid(v2),
      .d(res), .q_valid(out_valid), .q(output_data)
   );
   always_ff @(posedge clk) begin
      if (rst) acc <= '0;
      else if (advance && v2 && m2 == MODE_ACC) acc <= acc_next;
      else if (acc_clear) acc <= '0;
   end
   always_ff @(posedge clk) begin
      if (rst) out_count <= '0;
      else if (out_valid && out_ready) out_count <= out_count + 16'd1;
   end
endmodule

// File: tb/tb_expr_pipe_core.sv
// tb_expr_pipe_core: directed self-checking bench for expr_pipe_core
module tb_expr_pipe_core;
   import expr_pipe_pkg::*;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_mode = 1'b0;
   logic       acc_clear = 1'b0;
   logic       out_ready = 1'b1;
   logic [6:0] input_data = '0;
   logic       in_ready, out_valid;
   logic [8:0] output_data;
   logic [15:0] out_count;
   int checks = 0;
   int errors = 0;
   logic [8:0] got[$];
   logic [8:0] exp_q[$];
   logic [8:0] held;
   logic [23:0] ref_v;
   logic [6:0] sx [8] = '{7'h00, 7'h7F, 7'h10, 7'h02, 7'h04, 7'h7F, 7'h10, 7'h02};

   expr_pipe_core dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .input_data(input_data), .in_mode(in_mode), .acc_clear(acc_clear),
      .out_valid(out_valid), .out_ready(out_ready), .output_data(output_data),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (out_valid && out_ready) got.push_back(output_data);

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [6:0] x, input logic m);
      int n = 0;
      in_valid = 1'b1;
      input_data = x;
      in_mode = m;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("send_wait", 32'(n >= 50), 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic chk_q(input string tag);
      chk({tag, "_n"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, got[i], exp_q[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      idle(2);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", output_data, 0);
      chk("rst_count", out_count, 0);
      chk("rst_acc", dut.acc, 0);
      rst = 1'b0;
      idle(1);
      chk("rdy_after_rst", in_ready, 1);
      ref_v = expr_ref(7'h00, MODE_EXPR, 24'h0);
      chk("ref_expr0", ref_v[8:0], 9'h186);

      got.delete();
      send(7'h00, MODE_EXPR);
      chk("lat_n1", out_valid, 0);
      idle(1);
      chk("lat_n2", out_valid, 0);
      idle(1);
      chk("lat_n3", out_valid, 1);
      chk("expr_00", output_data, 9'h186);
      idle(1);
      chk("count_1", out_count, 1);

      idle(2);
      got.delete();
      send(7'h7F, MODE_EXPR);
      idle(5);
      exp_q = '{9'h15E};
      chk_q("expr_7f");

      got.delete();
      send(7'h00, MODE_ACC);
      send(7'h00, MODE_ACC);
      idle(5);
      exp_q = '{9'h1A9, 9'h152};
      chk_q("acc_b2b");
      chk("acc_b2b_val", dut.acc, 24'h8F1752);

      acc_clear = 1'b1;
      idle(1);
      acc_clear = 1'b0;
      chk("acc_clear_alone", dut.acc, 0);
      got.delete();
      send(7'h00, MODE_ACC);
      send(7'h00, MODE_ACC);
      idle(1);
      acc_clear = 1'b1;
      idle(1);
      acc_clear = 1'b0;
      idle(4);
      exp_q = '{9'h1A9, 9'h1A9};
      chk_q("acc_clr_add");
      chk("acc_clr_val", dut.acc, 24'h478BA9);

      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      got.delete();
      fork
         for (int i = 0; i < 8; i++) send(sx[i], MODE_EXPR);
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            #1 held = output_data;
            chk("stall_first", held, 9'h15E);
            for (int j = 0; j < 4; j++) begin
               chk("stall_rdy", in_ready, 0);
               chk("stall_valid", out_valid, 1);
               chk("stall_hold", output_data, held);
               idle(1);
            end
            out_ready = 1'b1;
         end
      join
      idle(8);
      exp_q = '{9'h186, 9'h15E, 9'h176, 9'h184, 9'h182, 9'h15E, 9'h176, 9'h184};
      chk_q("stream");
      chk("stream_count", out_count, 8);

      send(7'h00, MODE_ACC);
      idle(4);
      chk("pre_rst_acc", dut.acc, 24'h478BA9);
      got.delete();
      send(7'h00, MODE_ACC);
      send(7'h7F, MODE_ACC);
      in_valid = 1'b1;
      input_data = 7'h02;
      in_mode = MODE_ACC;
      rst = 1'b1;
      idle(1);
      in_valid = 1'b0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_count", out_count, 0);
      chk("mid_rst_acc", dut.acc, 0);
      rst = 1'b0;
      idle(6);
      chk("mid_rst_stale", got.size(), 0);
      chk("mid_rst_idle", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
